// File: rtl/frame_mem_pkg.sv
// Shared types and constants for the frame RAM arbiter: buffer geometry,
// arbiter state encoding and the buffered write request record.
package frame_mem_pkg;

    localparam int ADDR_W     = 19;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = 160000;

    localparam logic [ADDR_W-1:0] BUF0_BASE = 19'd0;
    localparam logic [ADDR_W-1:0] BUF1_BASE = 19'd160000;

    typedef enum logic {
        RUN       = 1'b0,
        SWAP_PEND = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_req_t;

    function automatic logic [ADDR_W-1:0] buf_base(input logic sel);
        return sel ? BUF1_BASE : BUF0_BASE;
    endfunction

endpackage

// File: rtl/frame_mem_arbiter_wr_fifo.sv
// Small synchronous FIFO of write requests feeding the RAM write path.
// Push and pop may occur in the same cycle; the caller never pushes when full.
module wr_fifo
    import frame_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           push,
    input  wr_req_t        push_req,
    input  logic           pop,
    output wr_req_t        head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    wr_req_t           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_25) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Frame RAM arbiter: display reads own the RAM inside the image window, buffered
// writes drain outside it, and buffer swaps are deferred to the frame boundary.
module frame_mem_arbiter
    import frame_mem_pkg::*;
#(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 400,
    parameter int H_START    = 120,
    parameter int V_START    = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic [9:0]        hs,
    input  logic [9:0]        vs,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [PIX_W-1:0]  disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [PIX_W-1:0]  mem_rdata,
    output arb_state_t        dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [9:0] H_LO = 10'(H_START);
    localparam logic [9:0] H_HI = 10'(H_START + IMG_WIDTH);
    localparam logic [9:0] V_LO = 10'(V_START);
    localparam logic [9:0] V_HI = 10'(V_START + IMG_HEIGHT);

    // Handshake: a write transfers on any rising edge where wr_valid and
    // wr_ready are both high; wr_ready is a register and never depends on wr_valid.

    arb_state_t        state;
    arb_state_t        state_next;
    logic              disp_win;
    logic              at_boundary;
    logic              swap_fire;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  cnt_next;
    wr_req_t           push_req;
    wr_req_t           head;
    logic [ADDR_W-1:0] front_base;
    logic [ADDR_W-1:0] back_base;

    assign disp_win    = (hs >= H_LO) && (hs < H_HI) && (vs >= V_LO) && (vs < V_HI);
    assign at_boundary = (hs == 10'd0) && (vs == V_HI);
    assign swap_fire   = (state == SWAP_PEND) && at_boundary && fifo_empty;

    assign push     = wr_valid & wr_ready;
    assign pop      = ~disp_win & ~fifo_empty;
    assign push_req = '{addr: wr_addr, data: wr_data};

    assign front_base = buf_base(front_sel);
    assign back_base  = buf_base(~front_sel);

    assign disp_data = mem_rdata;
    assign dbg_state = state;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_next = state;
        case (state)
            RUN:       if (swap_req)  state_next = SWAP_PEND;
            SWAP_PEND: if (swap_fire) state_next = RUN;
            default:   state_next = RUN;
        endcase
    end

    // Ready looks one cycle ahead so a full FIFO with a pop reopens next cycle.
    always_comb begin
        cnt_next = fifo_count;
        if (push && !pop) begin
            cnt_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            cnt_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wr_ready  <= 1'b0;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_next;
            wr_ready  <= (state_next == RUN) && (cnt_next != CNT_W'(FIFO_DEPTH));
            swap_done <= swap_fire;
            if (swap_fire) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // The display owns the RAM inside the window; otherwise drain one write.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (disp_win) begin
            mem_addr <= front_base + disp_addr;
            mem_we   <= 1'b0;
        end else if (pop) begin
            mem_addr  <= back_base + head.addr;
            mem_wdata <= head.data;
            mem_we    <= 1'b1;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // A fifo_full-derived ready must never permit a push into a full FIFO.
    always_ff @(posedge clk_25) begin
        if (rst_n && push) begin
            assert (!fifo_full);
        end
    end

endmodule
